// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline front-end sequencing controller:
// state encoding, default opcodes, default widths and the bundle of
// enable/flush outputs with the constant patterns the controller drives.
package pipe_ctrl_pkg;

    localparam int REGW_DEF = 3;
    localparam int OPW_DEF  = 2;
    localparam int CNTW_DEF = 8;

    localparam logic [1:0] OP_LOAD_DEF = 2'b10;
    localparam logic [1:0] OP_JUMP_DEF = 2'b11;

    // Encoding is visible on ctrl_state, so the values are pinned.
    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_FLUSH = 2'd2
    } ctrl_state_e;

    // One cycle's worth of front-end control.
    typedef struct packed {
        logic pc_we;
        logic pc_sel_jump;
        logic if_id_we;
        logic if_id_flush;
        logic id_ex_bubble;
    } ctrl_out_t;

    // Normal advance: PC+1, IF/ID captures the next instruction.
    localparam ctrl_out_t OUT_RUN = '{
        pc_we: 1'b1, pc_sel_jump: 1'b0, if_id_we: 1'b1,
        if_id_flush: 1'b0, id_ex_bubble: 1'b0
    };
    // Held in reset: nothing advances and both pipeline registers see NOPs.
    localparam ctrl_out_t OUT_RESET = '{
        pc_we: 1'b0, pc_sel_jump: 1'b0, if_id_we: 1'b0,
        if_id_flush: 1'b1, id_ex_bubble: 1'b1
    };
    // Load-use stall: freeze PC and IF/ID, push a bubble into ID/EX.
    localparam ctrl_out_t OUT_STALL = '{
        pc_we: 1'b0, pc_sel_jump: 1'b0, if_id_we: 1'b0,
        if_id_flush: 1'b0, id_ex_bubble: 1'b1
    };
    // External halt: same freeze as a stall; the FSM itself is also frozen.
    localparam ctrl_out_t OUT_HALT = OUT_STALL;
    // Jump cycle: load the target and squash the wrong-path fetch.
    localparam ctrl_out_t OUT_JUMP = '{
        pc_we: 1'b1, pc_sel_jump: 1'b1, if_id_we: 1'b1,
        if_id_flush: 1'b1, id_ex_bubble: 1'b0
    };
    // Post-jump flush while I-mem catches up with the redirected PC.
    localparam ctrl_out_t OUT_FLUSH = '{
        pc_we: 1'b1, pc_sel_jump: 1'b0, if_id_we: 1'b1,
        if_id_flush: 1'b1, id_ex_bubble: 1'b0
    };

    // Bits needed to hold values 0..max_val (at least one bit).
    function automatic int cnt_width(input int max_val);
        int w;
        w = 1;
        while ((1 << w) <= max_val) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detector. Flags when the instruction in ID/EX is a load
// whose destination is read by the instruction currently in IF/ID. Purely
// combinational so the forwarding unit can reuse it unchanged.
module hazard_detect
    import pipe_ctrl_pkg::*;
#(
    parameter int             REGW    = REGW_DEF,
    parameter int             OPW     = OPW_DEF,
    parameter logic [OPW-1:0] OP_LOAD = OPW'(OP_LOAD_DEF)
) (
    input  logic [OPW-1:0]  opcode_id_ex_i,
    input  logic [REGW-1:0] rd_id_ex_i,
    input  logic [REGW-1:0] rd_if_id_i,
    input  logic [REGW-1:0] rs_if_id_i,
    output logic            load_use_o
);

    logic is_load;
    logic src_match;

    assign is_load    = (opcode_id_ex_i == OP_LOAD);
    assign src_match  = (rd_id_ex_i == rd_if_id_i) || (rd_id_ex_i == rs_if_id_i);
    assign load_use_o = is_load && src_match;

endmodule

// File: rtl/pipe_seq_ctrl.sv
// Front-end sequencing controller for the 8-bit pipelined processor.
// Each cycle it decides whether PC and IF/ID advance, hold or flush, inserts
// ID/EX bubbles on load-use hazards, redirects fetch on jumps and honours an
// external halt. Priority: halt_req > load-use > jump.
// Optional feature: define HAZ_PERF_EN to add the saturating stall_count /
// flush_count performance counters (and the CNTW parameter).
module pipe_seq_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int             REGW      = REGW_DEF,
    parameter int             OPW       = OPW_DEF,
    parameter logic [OPW-1:0] OP_LOAD   = OPW'(OP_LOAD_DEF),
    parameter logic [OPW-1:0] OP_JUMP   = OPW'(OP_JUMP_DEF),
    parameter int             STALL_CYC = 1,
    parameter int             FLUSH_CYC = 1
`ifdef HAZ_PERF_EN
    ,
    parameter int             CNTW      = CNTW_DEF
`endif
) (
    input  logic            clk,
    input  logic            Reset,
    input  logic            halt_req,
    input  logic [OPW-1:0]  opcode_IF_ID,
    input  logic [REGW-1:0] RegRd_IF_ID,
    input  logic [REGW-1:0] RegRs_IF_ID,
    input  logic [OPW-1:0]  opcode_ID_EX,
    input  logic [REGW-1:0] RegRd_ID_EX,
    output logic            pc_we,
    output logic            pc_sel_jump,
    output logic            if_id_we,
    output logic            if_id_flush,
    output logic            id_ex_bubble,
    output logic [1:0]      ctrl_state
`ifdef HAZ_PERF_EN
    ,
    output logic [CNTW-1:0] stall_count,
    output logic [CNTW-1:0] flush_count
`endif
);

    // The down-counter must hold the longer of the two multi-cycle sequences.
    localparam int CNT_MAX = (STALL_CYC > FLUSH_CYC) ? STALL_CYC : FLUSH_CYC;
    localparam int CW      = cnt_width(CNT_MAX);

    localparam logic [CW-1:0] CNT_ONE      = CW'(1);
    localparam logic [CW-1:0] CNT_STALL_LD = CW'(STALL_CYC - 1);
    localparam logic [CW-1:0] CNT_FLUSH_LD = CW'(FLUSH_CYC);

    ctrl_state_e   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    ctrl_out_t     out_c;
    logic          load_use;
    logic          is_jump;

    hazard_detect #(
        .REGW    (REGW),
        .OPW     (OPW),
        .OP_LOAD (OP_LOAD)
    ) u_hazard_detect (
        .opcode_id_ex_i (opcode_ID_EX),
        .rd_id_ex_i     (RegRd_ID_EX),
        .rd_if_id_i     (RegRd_IF_ID),
        .rs_if_id_i     (RegRs_IF_ID),
        .load_use_o     (load_use)
    );

    assign is_jump = (opcode_IF_ID == OP_JUMP);

    // State and remaining-cycle counter; a reset aborts any stall/flush in flight.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values, whatever the block order.
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and output decode from the registered state and the current inputs.
    always_comb begin
        // NOTE: every variable gets a default first, so no path can infer a latch.
        out_c   = OUT_RUN;
        state_d = state_q;
        cnt_d   = cnt_q;

        if (!Reset) begin
            out_c = OUT_RESET;
        end else if (halt_req) begin
            // State and count stay put so the sequence resumes exactly where it stopped.
            out_c = OUT_HALT;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (load_use) begin
                        out_c   = OUT_STALL;
                        cnt_d   = CNT_STALL_LD;
                        state_d = (STALL_CYC > 1) ? ST_STALL : ST_RUN;
                    end else if (is_jump) begin
                        out_c   = OUT_JUMP;
                        cnt_d   = CNT_FLUSH_LD;
                        state_d = (FLUSH_CYC > 0) ? ST_FLUSH : ST_RUN;
                    end
                end
                ST_STALL: begin
                    // Hazard is not re-evaluated here; RUN re-checks it on return.
                    out_c = OUT_STALL;
                    cnt_d = cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        state_d = ST_RUN;
                    end
                end
                ST_FLUSH: begin
                    // A jump opcode still in IF/ID is wrong-path and is ignored.
                    out_c = OUT_FLUSH;
                    cnt_d = cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        state_d = ST_RUN;
                    end
                end
                default: begin
                    // Unused encoding: recover to RUN with a clean counter.
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    assign pc_we        = out_c.pc_we;
    assign pc_sel_jump  = out_c.pc_sel_jump;
    assign if_id_we     = out_c.if_id_we;
    assign if_id_flush  = out_c.if_id_flush;
    assign id_ex_bubble = out_c.id_ex_bubble;
    assign ctrl_state   = state_q;

`ifdef HAZ_PERF_EN
    localparam logic [CNTW-1:0] PERF_SAT = '1;
    localparam logic [CNTW-1:0] PERF_ONE = CNTW'(1);

    logic            stall_evt;
    logic            jump_evt;
    logic [CNTW-1:0] stall_cnt_q;
    logic [CNTW-1:0] flush_cnt_q;

    // Events are the RUN-state entry cycles only; halted cycles never count.
    assign stall_evt = !halt_req && (state_q == ST_RUN) && load_use;
    assign jump_evt  = !halt_req && (state_q == ST_RUN) && !load_use && is_jump;

    // Saturating performance counters, cleared by reset.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall_evt && (stall_cnt_q != PERF_SAT)) begin
                stall_cnt_q <= stall_cnt_q + PERF_ONE;
            end
            if (jump_evt && (flush_cnt_q != PERF_SAT)) begin
                flush_cnt_q <= flush_cnt_q + PERF_ONE;
            end
        end
    end

    assign stall_count = stall_cnt_q;
    assign flush_count = flush_cnt_q;
`else
    // Performance counters compiled out: no ports, no state.
`endif

endmodule

// File: tb/tb_pipe_seq_ctrl.sv
// Bench for pipe_seq_ctrl. Two instances share the same inputs:
//   dut_a: STALL_CYC=2, FLUSH_CYC=1 (CNTW=2 when HAZ_PERF_EN is defined)
//   dut_b: STALL_CYC=1, FLUSH_CYC=0 (default CNTW)
// Output word layout: {pc_we, pc_sel_jump, if_id_we, if_id_flush, id_ex_bubble, ctrl_state[1:0]}.
module tb_pipe_seq_ctrl;

    logic       clk;
    logic       Reset;
    logic       halt_req;
    logic [1:0] opcode_IF_ID;
    logic [2:0] RegRd_IF_ID;
    logic [2:0] RegRs_IF_ID;
    logic [1:0] opcode_ID_EX;
    logic [2:0] RegRd_ID_EX;

    logic       a_pc_we, a_sel, a_ifwe, a_flush, a_bub;
    logic [1:0] a_state;
    logic       b_pc_we, b_sel, b_ifwe, b_flush, b_bub;
    logic [1:0] b_state;
    logic [6:0] outs_a, outs_b;

    assign outs_a = {a_pc_we, a_sel, a_ifwe, a_flush, a_bub, a_state};
    assign outs_b = {b_pc_we, b_sel, b_ifwe, b_flush, b_bub, b_state};

`ifdef HAZ_PERF_EN
    logic [1:0] a_stall_count, a_flush_count;
    logic [7:0] b_stall_count, b_flush_count;
`endif

    localparam logic [6:0] O_RST   = 7'b0001100;
    localparam logic [6:0] O_RUN   = 7'b1010000;
    localparam logic [6:0] O_STALL = 7'b0000100;
    localparam logic [6:0] O_JUMP  = 7'b1111000;

    int n_pass  = 0;
    int n_total = 0;

    pipe_seq_ctrl #(
        .STALL_CYC (2),
        .FLUSH_CYC (1)
`ifdef HAZ_PERF_EN
        ,
        .CNTW      (2)
`endif
    ) dut_a (
        .clk          (clk),
        .Reset        (Reset),
        .halt_req     (halt_req),
        .opcode_IF_ID (opcode_IF_ID),
        .RegRd_IF_ID  (RegRd_IF_ID),
        .RegRs_IF_ID  (RegRs_IF_ID),
        .opcode_ID_EX (opcode_ID_EX),
        .RegRd_ID_EX  (RegRd_ID_EX),
        .pc_we        (a_pc_we),
        .pc_sel_jump  (a_sel),
        .if_id_we     (a_ifwe),
        .if_id_flush  (a_flush),
        .id_ex_bubble (a_bub),
        .ctrl_state   (a_state)
`ifdef HAZ_PERF_EN
        ,
        .stall_count  (a_stall_count),
        .flush_count  (a_flush_count)
`endif
    );

    pipe_seq_ctrl #(
        .STALL_CYC (1),
        .FLUSH_CYC (0)
    ) dut_b (
        .clk          (clk),
        .Reset        (Reset),
        .halt_req     (halt_req),
        .opcode_IF_ID (opcode_IF_ID),
        .RegRd_IF_ID  (RegRd_IF_ID),
        .RegRs_IF_ID  (RegRs_IF_ID),
        .opcode_ID_EX (opcode_ID_EX),
        .RegRd_ID_EX  (RegRd_ID_EX),
        .pc_we        (b_pc_we),
        .pc_sel_jump  (b_sel),
        .if_id_we     (b_ifwe),
        .if_id_flush  (b_flush),
        .id_ex_bubble (b_bub),
        .ctrl_state   (b_state)
`ifdef HAZ_PERF_EN
        ,
        .stall_count  (b_stall_count),
        .flush_count  (b_flush_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Tracks how many stall / flush cycles are still owed, per instance.
    int stall_cyc_m[2] = '{2, 1};
    int flush_cyc_m[2] = '{1, 0};
    int sat_m[2]       = '{3, 255};
    int stall_left[2];
    int flush_left[2];
    int stall_evts[2];
    int jump_evts[2];

    function automatic logic lu_now();
        return (opcode_ID_EX == 2'b10) &&
               ((RegRd_ID_EX == RegRd_IF_ID) || (RegRd_ID_EX == RegRs_IF_ID));
    endfunction

    function automatic logic [6:0] model_exp(input int i);
        logic [1:0] st;
        if (stall_left[i] > 0)      st = 2'd1;
        else if (flush_left[i] > 0) st = 2'd2;
        else                        st = 2'd0;
        if (!Reset)                  return O_RST;
        if (halt_req)                return {5'b00001, st};
        if (stall_left[i] > 0)       return {5'b00001, st};
        if (flush_left[i] > 0)       return {5'b10110, st};
        if (lu_now())                return O_STALL;
        if (opcode_IF_ID == 2'b11)   return O_JUMP;
        return O_RUN;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 2; i++) begin
            stall_left[i] = 0;
            flush_left[i] = 0;
            stall_evts[i] = 0;
            jump_evts[i]  = 0;
        end
    endtask

    task automatic model_step(input int i);
        if (!Reset) begin
            stall_left[i] = 0;
            flush_left[i] = 0;
            stall_evts[i] = 0;
            jump_evts[i]  = 0;
        end else if (halt_req) begin
            // frozen
        end else if (stall_left[i] > 0) begin
            stall_left[i]--;
        end else if (flush_left[i] > 0) begin
            flush_left[i]--;
        end else if (lu_now()) begin
            stall_left[i] = stall_cyc_m[i] - 1;
            stall_evts[i]++;
        end else if (opcode_IF_ID == 2'b11) begin
            flush_left[i] = flush_cyc_m[i];
            jump_evts[i]++;
        end
    endtask

    function automatic logic [15:0] sat_exp(input int evts, input int sat);
        return 16'((evts > sat) ? sat : evts);
    endfunction

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    // Drive a full input set shortly after the active edge, then let it settle.
    task automatic set_inputs(input logic rst, input logic halt, input logic [1:0] op_ifid,
                              input logic [2:0] rd, input logic [2:0] rs,
                              input logic [1:0] op_idex, input logic [2:0] rd_idex);
        Reset        = rst;
        halt_req     = halt;
        opcode_IF_ID = op_ifid;
        RegRd_IF_ID  = rd;
        RegRs_IF_ID  = rs;
        opcode_ID_EX = op_idex;
        RegRd_ID_EX  = rd_idex;
        if (!rst) model_clear();
        #1;
    endtask

    task automatic nop(input logic rst);
        set_inputs(rst, 1'b0, 2'b00, 3'd0, 3'd1, 2'b00, 3'd2);
    endtask

    task automatic reset_pulse();
        nop(1'b0);
        nop(1'b1);
    endtask

    // Compare both instances with the model, then advance one clock.
    task automatic run_cycle(input string tag);
        check({tag, "/a"}, 16'(outs_a), 16'(model_exp(0)));
        check({tag, "/b"}, 16'(outs_b), 16'(model_exp(1)));
`ifdef HAZ_PERF_EN
        check({tag, "/a_scnt"}, 16'(a_stall_count), sat_exp(stall_evts[0], sat_m[0]));
        check({tag, "/a_fcnt"}, 16'(a_flush_count), sat_exp(jump_evts[0], sat_m[0]));
        check({tag, "/b_scnt"}, 16'(b_stall_count), sat_exp(stall_evts[1], sat_m[1]));
        check({tag, "/b_fcnt"}, 16'(b_flush_count), sat_exp(jump_evts[1], sat_m[1]));
`endif
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
    endtask

    // ---------------- single-cycle vector table ----------------
    typedef struct {
        logic       rst;
        logic       halt;
        logic [1:0] op_ifid;
        logic [2:0] rd;
        logic [2:0] rs;
        logic [1:0] op_idex;
        logic [2:0] rd_idex;
        logic [6:0] exp;
    } vec_t;

    vec_t vecs[11];

    initial begin
        vecs[0]  = '{1'b0, 1'b0, 2'b11, 3'd3, 3'd3, 2'b10, 3'd3, O_RST};   // reset wins over everything
        vecs[1]  = '{1'b1, 1'b0, 2'b00, 3'd1, 3'd2, 2'b00, 3'd4, O_RUN};   // plain advance
        vecs[2]  = '{1'b1, 1'b0, 2'b01, 3'd3, 3'd5, 2'b10, 3'd3, O_STALL}; // load-use via Rd
        vecs[3]  = '{1'b1, 1'b0, 2'b01, 3'd5, 3'd3, 2'b10, 3'd3, O_STALL}; // load-use via Rs
        vecs[4]  = '{1'b1, 1'b0, 2'b01, 3'd5, 3'd6, 2'b10, 3'd3, O_RUN};   // load, no match
        vecs[5]  = '{1'b1, 1'b0, 2'b01, 3'd3, 3'd3, 2'b01, 3'd3, O_RUN};   // match but not a load
        vecs[6]  = '{1'b1, 1'b0, 2'b11, 3'd0, 3'd1, 2'b00, 3'd7, O_JUMP};  // jump
        vecs[7]  = '{1'b1, 1'b0, 2'b11, 3'd7, 3'd0, 2'b10, 3'd7, O_STALL}; // load-use beats jump
        vecs[8]  = '{1'b1, 1'b1, 2'b11, 3'd0, 3'd1, 2'b00, 3'd7, O_STALL}; // halt beats jump
        vecs[9]  = '{1'b1, 1'b1, 2'b01, 3'd2, 3'd2, 2'b10, 3'd2, O_STALL}; // halt with load-use
        vecs[10] = '{1'b0, 1'b1, 2'b00, 3'd0, 3'd0, 2'b00, 3'd0, O_RST};   // reset beats halt

        Reset = 1'b0;
        nop(1'b0);
        @(posedge clk);
        #1;

        // Reset held low with random inputs.
        for (int k = 0; k < 4; k++) begin
            set_inputs(1'b0, 1'($urandom_range(1)), 2'($urandom_range(3)), 3'($urandom_range(7)),
                       3'($urandom_range(7)), 2'($urandom_range(3)), 3'($urandom_range(7)));
            check("rst_hold_a", 16'(outs_a), 16'(O_RST));
            run_cycle("rst_hold");
        end

        // Table: each vector applied from a freshly reset RUN state.
        for (int v = 0; v < 11; v++) begin
            nop(1'b0);
            set_inputs(vecs[v].rst, vecs[v].halt, vecs[v].op_ifid, vecs[v].rd,
                       vecs[v].rs, vecs[v].op_idex, vecs[v].rd_idex);
            check($sformatf("vec%0d/a", v), 16'(outs_a), 16'(vecs[v].exp));
            check($sformatf("vec%0d/b", v), 16'(outs_b), 16'(vecs[v].exp));
            @(posedge clk);
            #1;
        end

        // Load-use with STALL_CYC=2: two frozen cycles, then advance.
        reset_pulse();
        set_inputs(1'b1, 1'b0, 2'b01, 3'd5, 3'd3, 2'b10, 3'd3);
        check("ldu_c0_a", 16'(outs_a), 16'(O_STALL));
        run_cycle("ldu_c0");
        set_inputs(1'b1, 1'b0, 2'b01, 3'd5, 3'd3, 2'b00, 3'd0);
        check("ldu_c1_a", 16'(outs_a), 16'(7'b0000101));
        run_cycle("ldu_c1");
        check("ldu_c2_a", 16'(outs_a), 16'(O_RUN));
        run_cycle("ldu_c2");

        // Jump with FLUSH_CYC=1; the jump opcode left in IF/ID is ignored in FLUSH.
        reset_pulse();
        set_inputs(1'b1, 1'b0, 2'b11, 3'd0, 3'd1, 2'b00, 3'd4);
        check("jmp_c0_a", 16'(outs_a), 16'(O_JUMP));
        run_cycle("jmp_c0");
        check("jmp_c1_a", 16'(outs_a), 16'(7'b1011010));
        run_cycle("jmp_c1");
        nop(1'b1);
        check("jmp_c2_a", 16'(outs_a), 16'(O_RUN));
        run_cycle("jmp_c2");

        // Load-use and jump together: stall first, jump on the first RUN cycle after.
        reset_pulse();
        set_inputs(1'b1, 1'b0, 2'b11, 3'd3, 3'd0, 2'b10, 3'd3);
        check("lj_c0_a", 16'(outs_a), 16'(O_STALL));
        run_cycle("lj_c0");
        set_inputs(1'b1, 1'b0, 2'b11, 3'd3, 3'd0, 2'b00, 3'd0);
        check("lj_c1_a", 16'(outs_a), 16'(7'b0000101));
        run_cycle("lj_c1");
        check("lj_c2_a", 16'(outs_a), 16'(O_JUMP));
        run_cycle("lj_c2");
        nop(1'b1);
        check("lj_c3_a", 16'(outs_a), 16'(7'b1011010));
        run_cycle("lj_c3");
        check("lj_c4_a", 16'(outs_a), 16'(O_RUN));
        run_cycle("lj_c4");

        // Halt for 3 cycles mid-FLUSH: frozen, then FLUSH resumes with its count intact.
        reset_pulse();
        set_inputs(1'b1, 1'b0, 2'b11, 3'd0, 3'd1, 2'b00, 3'd4);
        run_cycle("hlt_jump");
        for (int k = 0; k < 3; k++) begin
            set_inputs(1'b1, 1'b1, 2'b11, 3'd0, 3'd1, 2'b00, 3'd4);
            check($sformatf("hlt_frz%0d_a", k), 16'(outs_a), 16'(7'b0000110));
            run_cycle("hlt_frz");
        end
        set_inputs(1'b1, 1'b0, 2'b11, 3'd0, 3'd1, 2'b00, 3'd4);
        check("hlt_resume_a", 16'(outs_a), 16'(7'b1011010));
        run_cycle("hlt_resume");
        nop(1'b1);
        check("hlt_done_a", 16'(outs_a), 16'(O_RUN));
        run_cycle("hlt_done");

        // Reset pulse mid-STALL: straight back to RUN, no residual bubble.
        reset_pulse();
        set_inputs(1'b1, 1'b0, 2'b01, 3'd3, 3'd5, 2'b10, 3'd3);
        run_cycle("rst_stall_entry");
        set_inputs(1'b0, 1'b0, 2'b01, 3'd3, 3'd5, 2'b10, 3'd3);
        check("rst_stall_forced_a", 16'(outs_a), 16'(O_RST));
        run_cycle("rst_stall_low");
        nop(1'b1);
        check("rst_stall_after_a", 16'(outs_a), 16'(O_RUN));
        run_cycle("rst_stall_after");

`ifdef HAZ_PERF_EN
        // Five hazards saturate the 2-bit counter at 3; reset mid-STALL clears it.
        reset_pulse();
        for (int k = 0; k < 5; k++) begin
            set_inputs(1'b1, 1'b0, 2'b01, 3'd3, 3'd5, 2'b10, 3'd3);
            run_cycle("perf_haz");
            nop(1'b1);
            run_cycle("perf_gap");
        end
        check("perf_sat_a", 16'(a_stall_count), 16'd3);
        check("perf_cnt_b", 16'(b_stall_count), 16'd5);
        set_inputs(1'b1, 1'b0, 2'b01, 3'd3, 3'd5, 2'b10, 3'd3);
        run_cycle("perf_stall");
        nop(1'b0);
        check("perf_rst_a", 16'(a_stall_count), 16'd0);
        check("perf_rst_state_a", 16'(a_state), 16'd0);
        run_cycle("perf_rst");
`endif

        // Randomized traffic against the model.
        nop(1'b1);
        for (int k = 0; k < 3000; k++) begin
            set_inputs(1'($urandom_range(63) != 0), 1'($urandom_range(5) == 0),
                       2'($urandom_range(3)), 3'($urandom_range(7)), 3'($urandom_range(7)),
                       2'($urandom_range(3)), 3'($urandom_range(7)));
            run_cycle("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
